// File: rtl/piso_serializer_pkg.sv
// Shared encodings and helpers for the PISO serializer slice.
package piso_serializer_pkg;

  typedef logic state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_SHIFT = 1'b1;

  // Bit-count register width; a 2-bit word still needs one count bit.
  function automatic int count_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load-side and serial-side handshake bundle for the PISO serializer.
interface piso_serializer_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] pdata_in;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_last;
  logic             sout_ready;
  logic             busy;

  modport master (
    output pdata_in, load_valid, sout_ready,
    input  load_ready, sout, sout_valid, sout_last, busy
  );

  modport slave (
    input  pdata_in, load_valid, sout_ready,
    output load_ready, sout, sout_valid, sout_last, busy
  );

endinterface

// File: rtl/piso_serializer_bit_counter.sv
// Modulo-WIDTH bit counter with clear/enable and a registered terminal-count flag.
module piso_serializer_bit_counter
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CW = count_width(WIDTH);

  logic [CW-1:0] count_d, count_q;
  logic          terminal_d, terminal_q;

  // Terminal is precomputed from the next count so it lines up with the bit it marks.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = (count_q == CW'(WIDTH - 1)) ? '0 : count_q + CW'(1);
    end
    terminal_d = (count_d == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      terminal_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      terminal_q <= terminal_d;
    end
  end

  assign terminal = terminal_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage: accepts a word via valid/ready and shifts it out
// one bit per consumed beat, marking the final bit and streaming words gap-free.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic             clk,
  input logic             rst,
  piso_serializer_if.slave bus
);

  state_t           state_d, state_q;
  logic [WIDTH-1:0] shreg_d, shreg_q;
  logic             load_ready;
  logic             accept;
  logic             last_beat;
  logic             cnt_clear;
  logic             cnt_enable;
  logic             terminal;

  piso_serializer_bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .terminal(terminal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

  assign accept    = bus.load_valid && load_ready;
  assign last_beat = (state_q == ST_SHIFT) && terminal && bus.sout_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SHIFT;
      ST_SHIFT: if (last_beat) state_d = accept ? ST_SHIFT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The final-bit handoff reopens the load port so the next word follows with no bubble.
  always_comb begin
    load_ready = 1'b0;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    case (state_q)
      ST_IDLE: begin
        load_ready = 1'b1;
        cnt_clear  = 1'b1;
      end
      ST_SHIFT: begin
        load_ready = terminal && bus.sout_ready;
        cnt_clear  = terminal && bus.sout_ready;
        cnt_enable = bus.sout_ready && !terminal;
      end
      default: begin
        load_ready = 1'b0;
      end
    endcase
  end

  always_comb begin
    shreg_d = shreg_q;
    if (accept) begin
      shreg_d = bus.pdata_in;
    end else if (cnt_enable) begin
      shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
    end else if (last_beat) begin
      shreg_d = '0;
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.sout       = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign bus.sout_valid = (state_q == ST_SHIFT);
  assign bus.sout_last  = terminal;
  assign bus.busy       = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: MSB-first 4-bit, LSB-first 4-bit and LSB-first 8-bit instances.
module tb_piso_serializer;

  typedef struct {
    logic b;
    logic last;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  logic s_sout, s_valid, s_last, s_lready, s_busy;

  piso_serializer_if #(.WIDTH(4)) if4m ();
  piso_serializer_if #(.WIDTH(4)) if4l ();
  piso_serializer_if #(.WIDTH(8)) if8l ();

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut4m (.clk(clk), .rst(rst), .bus(if4m));
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut4l (.clk(clk), .rst(rst), .bus(if4l));
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut8l (.clk(clk), .rst(rst), .bus(if8l));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic set_in(input int sel, input logic lv, input logic [31:0] data, input logic sr);
    case (sel)
      0: begin if4m.load_valid = lv; if4m.pdata_in = data[3:0]; if4m.sout_ready = sr; end
      1: begin if4l.load_valid = lv; if4l.pdata_in = data[3:0]; if4l.sout_ready = sr; end
      default: begin if8l.load_valid = lv; if8l.pdata_in = data[7:0]; if8l.sout_ready = sr; end
    endcase
  endtask

  task automatic probe(input int sel);
    #1;
    case (sel)
      0: begin s_sout = if4m.sout; s_valid = if4m.sout_valid; s_last = if4m.sout_last;
               s_lready = if4m.load_ready; s_busy = if4m.busy; end
      1: begin s_sout = if4l.sout; s_valid = if4l.sout_valid; s_last = if4l.sout_last;
               s_lready = if4l.load_ready; s_busy = if4l.busy; end
      default: begin s_sout = if8l.sout; s_valid = if8l.sout_valid; s_last = if8l.sout_last;
               s_lready = if8l.load_ready; s_busy = if8l.busy; end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: expand a word into its expected bit sequence.
  function automatic void push_word(input logic [31:0] data, input int width, input logic msb);
    exp_t e;
    for (int i = 0; i < width; i++) begin
      e.b    = msb ? data[width-1-i] : data[i];
      e.last = (i == width - 1);
      sb.push_back(e);
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    set_in(0, 1'b1, 32'hF, 1'b1);
    set_in(1, 1'b0, 32'h0, 1'b1);
    set_in(2, 1'b0, 32'h0, 1'b1);
    for (int c = 0; c < 2; c++) begin
      step();
      probe(0);
      n_checks++;
      if (s_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", s_valid); end
      n_checks++;
      if (s_sout !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_sout: got %b expected 0", s_sout); end
      n_checks++;
      if (s_last !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_last: got %b expected 0", s_last); end
    end
    rst = 1'b0;
    set_in(0, 1'b0, 32'hF, 1'b1);
    probe(0);
    n_checks++;
    if (s_lready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_lready: got %b expected 1", s_lready); end
    n_checks++;
    if (s_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", s_busy); end
    step();
    probe(0);
    n_checks++;
    if (s_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_no_tx: got %b expected 0", s_valid); end
  endtask

  task automatic test_single_word();
    int   idx;
    logic lv, exp_valid, exp_lr;
    idx = 0;
    sb.delete();
    for (int c = 0; c < 20 && (sb.size() > 0 || idx < 1); c++) begin
      lv = (idx < 1);
      set_in(0, lv, 32'hB, 1'b1);
      probe(0);
      exp_valid = (sb.size() > 0);
      exp_lr = 1'b1;
      if (exp_valid) exp_lr = sb[0].last;
      n_checks++;
      if (s_valid !== exp_valid) begin n_fail++; $display("[TB] FAIL single_valid: got %b expected %b", s_valid, exp_valid); end
      n_checks++;
      if (s_lready !== exp_lr) begin n_fail++; $display("[TB] FAIL single_lready: got %b expected %b", s_lready, exp_lr); end
      if (exp_valid) begin
        n_checks++;
        if (s_sout !== sb[0].b) begin n_fail++; $display("[TB] FAIL single_sout: got %b expected %b", s_sout, sb[0].b); end
        n_checks++;
        if (s_last !== sb[0].last) begin n_fail++; $display("[TB] FAIL single_last: got %b expected %b", s_last, sb[0].last); end
        void'(sb.pop_front());
      end
      if (lv && s_lready) begin push_word(32'hB, 4, 1'b1); idx++; end
      step();
    end
    n_checks++;
    if (sb.size() != 0 || idx < 1) begin n_fail++; $display("[TB] FAIL single_timeout: %0d bits left expected 0", sb.size()); end
    set_in(0, 1'b0, 32'h0, 1'b1);
    probe(0);
    n_checks++;
    if ({s_valid, s_last, s_sout} !== 3'b000) begin
      n_fail++; $display("[TB] FAIL single_idle: got %b%b%b expected 000", s_valid, s_last, s_sout);
    end
  endtask

  task automatic test_stall();
    int   idx;
    logic lv, sr, exp_valid, exp_lr;
    idx = 0;
    sb.delete();
    for (int c = 0; c < 20 && (sb.size() > 0 || idx < 1); c++) begin
      sr = !(c >= 2 && c <= 4);
      lv = (idx < 1);
      set_in(0, lv, 32'hC, sr);
      probe(0);
      exp_valid = (sb.size() > 0);
      exp_lr = 1'b1;
      if (exp_valid) exp_lr = sb[0].last && sr;
      n_checks++;
      if (s_valid !== exp_valid) begin n_fail++; $display("[TB] FAIL stall_valid c%0d: got %b expected %b", c, s_valid, exp_valid); end
      n_checks++;
      if (s_busy !== exp_valid) begin n_fail++; $display("[TB] FAIL stall_busy c%0d: got %b expected %b", c, s_busy, exp_valid); end
      n_checks++;
      if (s_lready !== exp_lr) begin n_fail++; $display("[TB] FAIL stall_lready c%0d: got %b expected %b", c, s_lready, exp_lr); end
      if (exp_valid) begin
        n_checks++;
        if (s_sout !== sb[0].b) begin n_fail++; $display("[TB] FAIL stall_sout c%0d: got %b expected %b", c, s_sout, sb[0].b); end
        n_checks++;
        if (s_last !== sb[0].last) begin n_fail++; $display("[TB] FAIL stall_last c%0d: got %b expected %b", c, s_last, sb[0].last); end
        if (sr) void'(sb.pop_front());
      end
      if (lv && s_lready) begin push_word(32'hC, 4, 1'b1); idx++; end
      step();
    end
    n_checks++;
    if (sb.size() != 0 || idx < 1) begin n_fail++; $display("[TB] FAIL stall_timeout: %0d bits left expected 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words[2];
    int   idx;
    logic lv, exp_valid, exp_lr;
    words[0] = 32'hA;
    words[1] = 32'h5;
    idx = 0;
    sb.delete();
    for (int c = 0; c < 30 && (sb.size() > 0 || idx < 2); c++) begin
      lv = (idx < 2);
      if (lv) set_in(0, 1'b1, words[idx], 1'b1);
      else    set_in(0, 1'b0, 32'h0, 1'b1);
      probe(0);
      exp_valid = (sb.size() > 0);
      exp_lr = 1'b1;
      if (exp_valid) exp_lr = sb[0].last;
      n_checks++;
      if (s_valid !== exp_valid) begin n_fail++; $display("[TB] FAIL b2b_valid c%0d: got %b expected %b", c, s_valid, exp_valid); end
      n_checks++;
      if (s_lready !== exp_lr) begin n_fail++; $display("[TB] FAIL b2b_lready c%0d: got %b expected %b", c, s_lready, exp_lr); end
      if (exp_valid) begin
        n_checks++;
        if (s_sout !== sb[0].b) begin n_fail++; $display("[TB] FAIL b2b_sout c%0d: got %b expected %b", c, s_sout, sb[0].b); end
        n_checks++;
        if (s_last !== sb[0].last) begin n_fail++; $display("[TB] FAIL b2b_last c%0d: got %b expected %b", c, s_last, sb[0].last); end
        void'(sb.pop_front());
      end
      if (lv && s_lready) begin push_word(words[idx], 4, 1'b1); idx++; end
      step();
    end
    n_checks++;
    if (sb.size() != 0 || idx < 2) begin n_fail++; $display("[TB] FAIL b2b_timeout: %0d bits %0d words left expected 0", sb.size(), 2 - idx); end
  endtask

  task automatic test_reset_mid_word();
    int   idx;
    logic lv, exp_valid, exp_lr;
    set_in(0, 1'b1, 32'hF, 1'b1);
    probe(0);
    n_checks++;
    if (s_lready !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_accept: got %b expected 1", s_lready); end
    step();
    set_in(0, 1'b0, 32'h0, 1'b1);
    for (int c = 0; c < 2; c++) begin
      probe(0);
      n_checks++;
      if ({s_valid, s_sout} !== 2'b11) begin n_fail++; $display("[TB] FAIL midrst_bit%0d: got %b%b expected 11", c, s_valid, s_sout); end
      if (c == 0) step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      probe(0);
      n_checks++;
      if ({s_valid, s_lready, s_sout, s_last} !== 4'b0100) begin
        n_fail++; $display("[TB] FAIL midrst_after%0d: got v%b r%b s%b l%b expected v0 r1 s0 l0", c, s_valid, s_lready, s_sout, s_last);
      end
      step();
    end
    idx = 0;
    sb.delete();
    for (int c = 0; c < 20 && (sb.size() > 0 || idx < 1); c++) begin
      lv = (idx < 1);
      set_in(0, lv, 32'h6, 1'b1);
      probe(0);
      exp_valid = (sb.size() > 0);
      exp_lr = 1'b1;
      if (exp_valid) exp_lr = sb[0].last;
      n_checks++;
      if (s_valid !== exp_valid) begin n_fail++; $display("[TB] FAIL midrst_valid c%0d: got %b expected %b", c, s_valid, exp_valid); end
      n_checks++;
      if (s_lready !== exp_lr) begin n_fail++; $display("[TB] FAIL midrst_lready c%0d: got %b expected %b", c, s_lready, exp_lr); end
      if (exp_valid) begin
        n_checks++;
        if (s_sout !== sb[0].b) begin n_fail++; $display("[TB] FAIL midrst_sout c%0d: got %b expected %b", c, s_sout, sb[0].b); end
        n_checks++;
        if (s_last !== sb[0].last) begin n_fail++; $display("[TB] FAIL midrst_last c%0d: got %b expected %b", c, s_last, sb[0].last); end
        void'(sb.pop_front());
      end
      if (lv && s_lready) begin push_word(32'h6, 4, 1'b1); idx++; end
      step();
    end
    n_checks++;
    if (sb.size() != 0 || idx < 1) begin n_fail++; $display("[TB] FAIL midrst_timeout: %0d bits left expected 0", sb.size()); end
    set_in(0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_lsb_first();
    int          sel, width, idx;
    logic [31:0] data;
    logic        lv, exp_valid, exp_lr;
    for (int k = 0; k < 2; k++) begin
      sel   = (k == 0) ? 1 : 2;
      width = (k == 0) ? 4 : 8;
      data  = (k == 0) ? 32'h1 : 32'h81;
      idx = 0;
      sb.delete();
      for (int c = 0; c < 30 && (sb.size() > 0 || idx < 1); c++) begin
        lv = (idx < 1);
        set_in(sel, lv, data, 1'b1);
        probe(sel);
        exp_valid = (sb.size() > 0);
        exp_lr = 1'b1;
        if (exp_valid) exp_lr = sb[0].last;
        n_checks++;
        if (s_valid !== exp_valid) begin n_fail++; $display("[TB] FAIL lsb%0d_valid c%0d: got %b expected %b", width, c, s_valid, exp_valid); end
        n_checks++;
        if (s_lready !== exp_lr) begin n_fail++; $display("[TB] FAIL lsb%0d_lready c%0d: got %b expected %b", width, c, s_lready, exp_lr); end
        if (exp_valid) begin
          n_checks++;
          if (s_sout !== sb[0].b) begin n_fail++; $display("[TB] FAIL lsb%0d_sout c%0d: got %b expected %b", width, c, s_sout, sb[0].b); end
          n_checks++;
          if (s_last !== sb[0].last) begin n_fail++; $display("[TB] FAIL lsb%0d_last c%0d: got %b expected %b", width, c, s_last, sb[0].last); end
          void'(sb.pop_front());
        end
        if (lv && s_lready) begin push_word(data, width, 1'b0); idx++; end
        step();
      end
      n_checks++;
      if (sb.size() != 0 || idx < 1) begin n_fail++; $display("[TB] FAIL lsb%0d_timeout: %0d bits left expected 0", width, sb.size()); end
      set_in(sel, 1'b0, 32'h0, 1'b1);
      probe(sel);
      n_checks++;
      if ({s_valid, s_last, s_sout} !== 3'b000) begin
        n_fail++; $display("[TB] FAIL lsb%0d_idle: got %b%b%b expected 000", width, s_valid, s_last, s_sout);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    $display("[TB] starting piso_serializer bench");
    test_reset();
    test_single_word();
    test_stall();
    test_back_to_back();
    test_reset_mid_word();
    test_lsb_first();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
